// File: rtl/pcm_tdm_frame_ctrl_if.sv
// Bundle between the PCM TDM frame scheduler and its user: frame request,
// sample bus, shared-encoder loop and the serial frame stream.
interface pcm_tdm_frame_ctrl_if #(
  parameter int NCH = 4
);
  logic                 start;
  logic [13*NCH-1:0]    samples;
  logic [12:0]          enc_in;
  logic [7:0]           enc_out;
  logic                 ser_out;
  logic                 ser_valid;
  logic                 frame_sync;
  logic                 busy;
  logic                 done;

  // The master side owns the request, the samples and the encoder instance.
  modport master (
    output start, samples, enc_out,
    input  enc_in, ser_out, ser_valid, frame_sync, busy, done
  );

  modport slave (
    input  start, samples, enc_out,
    output enc_in, ser_out, ser_valid, frame_sync, busy, done
  );
endinterface

// File: rtl/pcm_tdm_frame_ctrl.sv
// TDM frame scheduler: snapshots NCH samples, time-shares one PCM encoder and
// serialises sync word plus one code per channel, MSB first, with no gaps.
module pcm_tdm_frame_ctrl #(
  parameter int         NCH       = 4,
  parameter logic [7:0] SYNC_WORD = 8'b10011011
) (
  input logic                 clk,
  input logic                 rst,
  pcm_tdm_frame_ctrl_if.slave bus
);
  localparam int             CPW      = $clog2(NCH + 1);
  localparam logic [CPW-1:0] LAST_PTR = CPW'(NCH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_CHAN
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [2:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [CPW-1:0] r_ch_ptr, w_ch_ptr_nxt;
  logic [12:0]    r_snap [NCH];
  logic           r_ser_valid;
  logic           r_frame_sync;
  logic           r_done;
  logic           w_last_bit;
  logic           w_accept;
  logic [12:0]    w_enc_in;

  // ch_ptr runs one ahead of the channel on the line: it names the sample
  // whose code will be loaded at the end of the current slot.
  assign w_last_bit = (r_state == S_CHAN) && (r_bit_cnt == 3'd7) && (r_ch_ptr == LAST_PTR);
  assign w_accept   = bus.start && ((r_state == S_IDLE) || w_last_bit);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_ch_ptr_nxt  = r_ch_ptr;
    if (w_accept) begin
      w_state_nxt   = S_SYNC;
      w_shift_nxt   = SYNC_WORD;
      w_bit_cnt_nxt = 3'd0;
      w_ch_ptr_nxt  = '0;
    end else if (r_state != S_IDLE) begin
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      w_shift_nxt   = {r_shift[6:0], 1'b0};
      if (r_bit_cnt == 3'd7) begin
        if (r_ch_ptr < LAST_PTR) begin
          w_state_nxt  = S_CHAN;
          w_shift_nxt  = bus.enc_out;
          w_ch_ptr_nxt = r_ch_ptr + CPW'(1);
        end else begin
          w_state_nxt   = S_IDLE;
          w_shift_nxt   = 8'd0;
          w_bit_cnt_nxt = 3'd0;
          w_ch_ptr_nxt  = '0;
        end
      end
    end
  end

  // Out-of-range pointer (last channel on the line) falls back to channel 0.
  always_comb begin
    w_enc_in = r_snap[0];
    for (int i = 1; i < NCH; i++) begin
      if (r_ch_ptr == CPW'(i)) w_enc_in = r_snap[i];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_ch_ptr     <= '0;
      r_ser_valid  <= 1'b0;
      r_frame_sync <= 1'b0;
      r_done       <= 1'b0;
      // NOTE: the snapshot array is cleared on reset because enc_in exposes it even while idle.
      for (int i = 0; i < NCH; i++) r_snap[i] <= 13'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_ch_ptr     <= w_ch_ptr_nxt;
      r_ser_valid  <= (w_state_nxt != S_IDLE);
      r_frame_sync <= (w_state_nxt == S_SYNC) && (w_bit_cnt_nxt == 3'd0);
      r_done       <= (w_state_nxt == S_CHAN) && (w_bit_cnt_nxt == 3'd7) &&
                      (w_ch_ptr_nxt == LAST_PTR);
      if (w_accept) begin
        for (int i = 0; i < NCH; i++) r_snap[i] <= bus.samples[13*i +: 13];
      end
    end
  end

  assign bus.enc_in     = w_enc_in;
  assign bus.ser_out    = r_shift[7];
  assign bus.ser_valid  = r_ser_valid;
  assign bus.busy       = r_ser_valid;
  assign bus.frame_sync = r_frame_sync;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_pcm_tdm_frame_ctrl.sv
// Scoreboard bench for pcm_tdm_frame_ctrl: a frame-level model predicts every
// output cycle; a negedge monitor pops and compares.
module tb_pcm_tdm_frame_ctrl;
  localparam int NCH = 4;

  typedef struct packed {
    logic ser;
    logic valid;
    logic sync;
    logic busy;
    logic done;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic enc_mode;  // 0: stub enc_out = enc_in[7:0], 1: A-law encoder

  int n_tests = 0;
  int n_fail  = 0;

  obs_t pend[$];
  obs_t exp_q[$];
  obs_t m_cur;

  pcm_tdm_frame_ctrl_if #(.NCH(NCH)) bus ();

  pcm_tdm_frame_ctrl #(.NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // G.711 A-law compression of a 13-bit two's-complement sample.
  function automatic logic [7:0] alaw(input logic [12:0] x);
    logic        s;
    logic [11:0] mag;
    logic [2:0]  seg;
    logic [3:0]  man;
    s   = x[12];
    mag = s ? ~x[11:0] : x[11:0];
    seg = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(mag) >= (32 << (i - 1))) seg = 3'(i);
    end
    man = (seg == 3'd0) ? mag[4:1] : 4'(mag >> seg);
    return {~s, seg, man} ^ 8'h55;
  endfunction

  function automatic logic [7:0] enc_model(input logic [12:0] x);
    return enc_mode ? alaw(x) : x[7:0];
  endfunction

  always_comb bus.enc_out = enc_model(bus.enc_in);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Whole frame expected from the samples present at the accepting edge.
  function automatic void build_frame(input logic [13*NCH-1:0] s);
    logic [7:0] word;
    for (int slot = 0; slot <= NCH; slot++) begin
      word = (slot == 0) ? 8'b10011011 : enc_model(s[13*(slot-1) +: 13]);
      for (int b = 7; b >= 0; b--) begin
        pend.push_back('{ser: word[b], valid: 1'b1, sync: (slot == 0 && b == 7),
                         busy: 1'b1, done: (slot == NCH && b == 0)});
      end
    end
  endfunction

  // Reference model: one expected output vector per clock edge.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
      m_cur = '0;
    end else begin
      if (bus.start && (!m_cur.valid || m_cur.done)) build_frame(bus.samples);
      m_cur = (pend.size() > 0) ? pend.pop_front() : obs_t'('0);
    end
    exp_q.push_back(m_cur);
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{ser: bus.ser_out, valid: bus.ser_valid, sync: bus.frame_sync,
            busy: bus.busy, done: bus.done};
      check("obs{ser,valid,sync,busy,done}", 32'(a), 32'(e));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 100) begin
      cyc(1);
      k++;
    end
    check(name, 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [13*NCH-1:0] rand_samples();
    logic [13*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[13*i +: 13] = 13'($urandom);
    return v;
  endfunction

  localparam logic [13*NCH-1:0] BASE = {13'h044, 13'h033, 13'h022, 13'h011};

  initial begin
    rst         = 1'b1;
    enc_mode    = 1'b0;
    bus.start   = 1'b0;
    bus.samples = BASE;
    cyc(3);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ser_out", 32'(bus.ser_out), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Basic frame
    pulse_start();
    cyc(40);
    check("basic_busy_after", 32'(bus.busy), 32'd0);
    cyc(3);

    // Snapshot isolation
    pulse_start();
    bus.samples = {NCH{13'h0FF}};
    cyc(45);
    check("snapshot_idle", 32'(bus.busy), 32'd0);
    bus.samples = BASE;

    // Back-to-back with samples changing every cycle
    bus.start = 1'b1;
    for (int i = 0; i < 130; i++) begin
      bus.samples = rand_samples();
      cyc(1);
    end
    bus.start = 1'b0;
    wait_idle("b2b_idle");
    cyc(2);

    // Ignored start at bit 10
    bus.samples = BASE;
    pulse_start();
    cyc(9);
    pulse_start();
    wait_idle("ignored_start_idle");
    cyc(2);

    // Mid-frame reset at bit 20, then a full frame
    pulse_start();
    cyc(19);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_midframe_busy", 32'(bus.busy), 32'd0);
    check("rst_midframe_done", 32'(bus.done), 32'd0);
    cyc(1);
    pulse_start();
    wait_idle("after_reset_frame_idle");
    cyc(2);

    // Random starts, samples and occasional resets
    for (int i = 0; i < 600; i++) begin
      bus.start   = ($urandom_range(0, 7) == 0);
      rst         = ($urandom_range(0, 149) == 0);
      bus.samples = rand_samples();
      cyc(1);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    wait_idle("random_idle");
    cyc(2);

    // A-law encoder with a ramp on channel 0
    enc_mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.samples = rand_samples();
      bus.samples[12:0] = 13'(32'h1000 + k * 547);
      pulse_start();
      wait_idle("alaw_frame_idle");
      cyc(1);
    end

    cyc(3);
    check("scoreboard_drained", 32'(exp_q.size() <= 1), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pcm_tdm_frame_ctrl.md
Name: pcm_tdm_frame_ctrl

Overview:
- Time-division frame scheduler for the shared PCM compressor (13-bit linear in, 8-bit code out, combinational).
- On each start request it snapshots NCH linear samples and sequences them one at a time through a single external encoder instance.
- It serialises a frame MSB-first: 8-bit sync word, then one 8-bit code per channel. The serial stream feeds the channel/line side of the design.

Parameters:
NCH, 4, number of channels per frame (1..16)
SYNC_WORD, 8'b10011011, frame alignment word sent before channel 0

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  frame request; sampled every cycle, accepted only when idle or on the last bit of a frame
samples  input  13*NCH  flat sample bus; channel k occupies [13k+12:13k]
enc_in  output  13  linear sample driven to the shared PCM encoder
enc_out  input  8  code returned combinationally by the encoder for enc_in
ser_out  output  1  serial frame data, MSB first
ser_valid  output  1  high on every cycle carrying a frame bit
frame_sync  output  1  high only on the first sync-word bit
busy  output  1  high from the first sync bit through the last channel bit
done  output  1  one-cycle pulse coincident with the last bit of the frame

Behaviour:
- Reset: all outputs 0; state=IDLE; snapshot registers, shift register, bit_cnt and ch_ptr all cleared.
- Mid-frame reset abandons the frame. At the next edge all outputs are 0 and there is no done pulse.
- States: IDLE, SYNC, CHAN. All serial outputs are registered.
- Acceptance: start=1 at edge E, with state IDLE or the current cycle being the last frame bit. Effects at E:
  - all NCH samples copied into snapshot registers;
  - shift register loaded with SYNC_WORD;
  - bit_cnt=0, ch_ptr=0;
  - state goes to SYNC.
- Start latency: first sync bit appears in the cycle after E. ser_valid=1, frame_sync=1, busy=1.
- start while busy and not on the last bit: ignored, no queueing.
- SYNC: 8 cycles. Shift left each edge; ser_out = shift_reg[7].
- Encoder sharing:
  - enc_in = snapshot[ch_ptr] at all times, combinationally.
  - At each edge ending bit 7 of a slot (sync or channel), while ch_ptr<NCH: shift_reg <= enc_out, ch_ptr increments, next state CHAN.
  - Result: no idle bits between slots.
- CHAN: 8 bits per channel, MSB first. Total frame length = 8*(NCH+1) consecutive valid cycles.
- Last bit (bit 7 of channel NCH-1):
  - done=1 in that same cycle;
  - if start=1, next frame begins seamlessly: busy and ser_valid stay high, new sync bit follows directly;
  - otherwise next state is IDLE with ser_valid=busy=0.
- IDLE: ser_out=0, ser_valid=0, frame_sync=0, enc_in=snapshot[0].
- Sample stability: changes on samples after acceptance do not affect the current frame (snapshot only).
- ch_ptr width: clog2(NCH+1).
- bit_cnt: 3 bits, wraps 7->0 at each slot boundary.

Test Plan:
1. Basic frame: NCH=4, bench stub enc_out=enc_in[7:0], samples ch0..3 = 13'h011, 13'h022, 13'h033, 13'h044, one-cycle start pulse.
   -> starting the cycle after the start edge, 40 valid bits: 10011011, 00010001, 00100010, 00110011, 01000100.
   -> frame_sync high on bit 0 only; done high on bit 39; busy low from bit 40.
2. Snapshot: same setup, change all samples to 13'h0FF one cycle after acceptance.
   -> stream identical to scenario 1.
3. Back-to-back: hold start=1 continuously.
   -> ser_valid never drops between frames.
   -> done and next frame_sync exactly 1 cycle apart; second frame uses samples present at the last-bit edge.
4. Ignored start: pulse start at bit 10 of a frame.
   -> no effect; frame completes at bit 39, then IDLE.
5. Reset mid-frame: assert rst during bit 20 of a frame.
   -> next cycle all outputs 0, no done pulse.
   -> a new start after reset produces a full correct frame.
6. Real encoder: connect the team's pcm encoder and a 13-bit linear ramp on channel 0.
   -> each channel-0 code in the stream equals the pcm encoder output for that sample.
   -> expanding those codes through r_pcm matches the reconstruction obtained by driving the same samples directly through pcm then r_pcm.
